// File: rtl/aes_pkg.sv
// Shared definitions for the AES-CBC decryption controller.
//   BLOCK_W         - AES block width in bits
//   DEFAULT_TIMEOUT - default core_done wait budget in cycles
//   ctrl_state_e    - controller FSM states
//   cnt_width()     - bits needed to count from 0 up to and including a limit
package aes_pkg;

  localparam int unsigned BLOCK_W         = 128;
  localparam int unsigned DEFAULT_TIMEOUT = 64;
  localparam int unsigned BLK_CNT_W       = 16;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StOut
  } ctrl_state_e;

  // The watchdog must be able to hold the limit value itself, so size for limit + 1 codes.
  function automatic int unsigned cnt_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/aes_wdog_cnt.sv
// Wait-state watchdog counter for the AES-CBC decryption controller.
//   clk     - clock, rising edge
//   reset   - synchronous active-high reset, counter to 0
//   clear   - synchronous clear to 0 (held while the controller is not waiting)
//   enable  - count one cycle of waiting
//   limit   - terminal count
//   expired - counter has reached limit (combinational from the count)
// The count saturates at limit so a late clear can never wrap it back below.
module aes_wdog_cnt #(
  parameter int unsigned Width = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [Width-1:0] limit,
  output logic             expired
);

  logic [Width-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/aes_cbc_dec_ctrl.sv
// AES-CBC decryption controller.
// Accepts one ciphertext block at a time, hands it to an external AES decryption core,
// XORs the core's result with the chaining value (IV for the first block of a message,
// otherwise the previous ciphertext) and presents the plaintext block downstream.
//   clk, reset            - clock and synchronous active-high reset
//   in_valid/in_ready     - ciphertext handshake; in_data block, in_first marks message start
//   iv                    - initialisation vector, sampled with an accepted in_first block
//   core_start            - one-cycle start pulse to the core
//   core_ciphertext       - block being decrypted, held from start until the core answers
//   core_plaintext/done   - core result and its completion strobe (only honoured while waiting)
//   out_valid/out_ready   - plaintext handshake; out_data held stable while out_valid
//   blk_count             - plaintext blocks delivered in the current message (wraps)
//   timeout_err           - sticky; core failed to answer within TIMEOUT_CYCLES
// The core must be reset together with this block (core reset_n = ~reset): a reset in
// mid-operation discards the block here, so a stale core_done must not survive either.
module aes_cbc_dec_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BLOCK_W-1:0]   in_data,
  input  logic                 in_first,
  input  logic [BLOCK_W-1:0]   iv,
  output logic                 core_start,
  output logic [BLOCK_W-1:0]   core_ciphertext,
  input  logic [BLOCK_W-1:0]   core_plaintext,
  input  logic                 core_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BLOCK_W-1:0]   out_data,
  output logic [BLK_CNT_W-1:0] blk_count,
  output logic                 timeout_err
);

  localparam int unsigned CntW = cnt_width(TIMEOUT_CYCLES);

  ctrl_state_e state_q, state_d;

  logic [BLOCK_W-1:0]   cur_ct_q, cur_ct_d;
  logic [BLOCK_W-1:0]   chain_q, chain_d;
  logic [BLOCK_W-1:0]   prev_ct_q, prev_ct_d;
  logic [BLOCK_W-1:0]   out_data_q, out_data_d;
  logic [BLK_CNT_W-1:0] blk_count_q, blk_count_d;
  logic                 timeout_err_q, timeout_err_d;

  logic wdog_expired;
  logic in_wait;

  assign in_wait = (state_q == StWait);

  // Counter sits at 0 outside WAIT, so it starts from 0 on every entry.
  aes_wdog_cnt #(
    .Width (CntW)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (!in_wait),
    .enable  (in_wait),
    .limit   (CntW'(TIMEOUT_CYCLES)),
    .expired (wdog_expired)
  );

  always_comb begin
    state_d       = state_q;
    cur_ct_d      = cur_ct_q;
    chain_d       = chain_q;
    prev_ct_d     = prev_ct_q;
    out_data_d    = out_data_q;
    blk_count_d   = blk_count_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          cur_ct_d = in_data;
          chain_d  = in_first ? iv : prev_ct_q;
          if (in_first) begin
            blk_count_d = '0;
          end
          state_d = StStart;
        end
      end

      StStart: begin
        state_d = StWait;
      end

      StWait: begin
        // core_done wins over expiry: an answer on the last allowed cycle is a success.
        if (core_done) begin
          out_data_d = core_plaintext ^ chain_q;
          prev_ct_d  = cur_ct_q;
          state_d    = StOut;
        end else if (wdog_expired) begin
          // Abandon the block; prev_ct keeps chaining from the last good block.
          timeout_err_d = 1'b1;
          state_d       = StIdle;
        end
      end

      StOut: begin
        if (out_ready) begin
          blk_count_d = blk_count_q + BLK_CNT_W'(1);
          state_d     = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cur_ct_q      <= '0;
      chain_q       <= '0;
      prev_ct_q     <= '0;
      out_data_q    <= '0;
      blk_count_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_ct_q      <= cur_ct_d;
      chain_q       <= chain_d;
      prev_ct_q     <= prev_ct_d;
      out_data_q    <= out_data_d;
      blk_count_q   <= blk_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign in_ready        = (state_q == StIdle);
  assign core_start      = (state_q == StStart);
  assign out_valid       = (state_q == StOut);
  assign core_ciphertext = cur_ct_q;
  assign out_data        = out_data_q;
  assign blk_count       = blk_count_q;
  assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_aes_cbc_dec_ctrl.sv
// Self-checking bench for aes_cbc_dec_ctrl. The bench plays the decryption core itself:
// the FIPS-197 known-answer block decrypts to its published plaintext, any other block
// goes through a simple invertible stand-in. A message-level CBC model predicts outputs.
module tb_aes_cbc_dec_ctrl;

  localparam int unsigned Tmo = 64;
  localparam logic [127:0] KatCt = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KatPt = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_first;
  logic [127:0] iv;
  logic         core_start;
  logic [127:0] core_ciphertext;
  logic [127:0] core_plaintext;
  logic         core_done;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [15:0]  blk_count;
  logic         timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: CBC chaining value, delivered-block count, sticky error.
  logic [127:0] m_prev;
  logic [15:0]  m_blk;
  logic         m_err;

  aes_cbc_dec_ctrl #(
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_first        (in_first),
    .iv              (iv),
    .core_start      (core_start),
    .core_ciphertext (core_ciphertext),
    .core_plaintext  (core_plaintext),
    .core_done       (core_done),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .blk_count       (blk_count),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in AES decryption: exact for the known-answer block, a fixed permutation otherwise.
  function automatic logic [127:0] core_dec(input logic [127:0] ct);
    if (ct == KatCt) return KatPt;
    return {ct[63:0], ct[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  task automatic model_reset();
    m_prev = '0;
    m_blk  = '0;
    m_err  = 1'b0;
  endtask

  // Push one block through. delay = WAIT cycles before core_done; delay > Tmo means the
  // core never answers. hold = cycles out_ready stays low in OUT.
  task automatic do_block(input logic [127:0] ct, input logic first, input logic [127:0] ivv,
                          input int delay, input int hold, input logic spur_start,
                          output logic [127:0] got);
    logic [127:0] chain;
    logic [127:0] exp;
    int guard;
    guard = 0;
    got   = '0;
    while (!in_ready && guard < 200) begin
      tick();
      guard++;
    end
    check("in_ready_idle", 128'(in_ready), 128'(1'b1));
    in_valid = 1'b1;
    in_data  = ct;
    in_first = first;
    iv       = ivv;
    tick();
    in_valid = 1'b0;
    in_first = $urandom_range(0, 1) != 0;
    in_data  = rand128();
    iv       = rand128();
    chain = first ? ivv : m_prev;
    if (first) m_blk = '0;
    check("core_start_pulse", 128'(core_start), 128'(1'b1));
    check("core_ct_start", core_ciphertext, ct);
    check("in_ready_busy", 128'(in_ready), 128'(1'b0));
    if (spur_start) begin
      core_done      = 1'b1;
      core_plaintext = rand128();
    end
    tick();
    core_done = 1'b0;
    check("core_start_one_cycle", 128'(core_start), 128'(1'b0));
    if (delay > int'(Tmo)) begin
      repeat (Tmo) tick();
      // Counter has reached the limit this cycle; still waiting, no error yet.
      check("to_still_wait", 128'(in_ready), 128'(1'b0));
      check("to_err_not_yet", 128'(timeout_err), 128'(m_err));
      tick();
      m_err = 1'b1;
      check("timeout_err", 128'(timeout_err), 128'(1'b1));
      check("to_idle", 128'(in_ready), 128'(1'b1));
      check("to_no_out", 128'(out_valid), 128'(1'b0));
      check("to_blk_count", 128'(blk_count), 128'(m_blk));
    end else begin
      repeat (delay) tick();
      check("core_ct_held", core_ciphertext, ct);
      check("no_early_out", 128'(out_valid), 128'(1'b0));
      core_done      = 1'b1;
      core_plaintext = core_dec(ct);
      tick();
      core_done      = 1'b0;
      core_plaintext = rand128();
      exp    = core_dec(ct) ^ chain;
      m_prev = ct;
      got    = out_data;
      check("out_valid", 128'(out_valid), 128'(1'b1));
      check("out_data", out_data, exp);
      for (int i = 0; i < hold; i++) begin
        tick();
        check("hold_out_data", out_data, exp);
        check("hold_out_valid", 128'(out_valid), 128'(1'b1));
        check("hold_in_ready", 128'(in_ready), 128'(1'b0));
        check("hold_no_start", 128'(core_start), 128'(1'b0));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      m_blk = m_blk + 16'd1;
      check("blk_count", 128'(blk_count), 128'(m_blk));
      check("out_done_idle", 128'(in_ready), 128'(1'b1));
      check("out_valid_drop", 128'(out_valid), 128'(1'b0));
      check("err_sticky", 128'(timeout_err), 128'(m_err));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1'b1));
    check({tag, "_out_valid"}, 128'(out_valid), 128'(1'b0));
    check({tag, "_core_start"}, 128'(core_start), 128'(1'b0));
    check({tag, "_out_data"}, out_data, '0);
    check({tag, "_core_ct"}, core_ciphertext, '0);
    check({tag, "_blk_count"}, 128'(blk_count), '0);
    check({tag, "_timeout_err"}, 128'(timeout_err), '0);
  endtask

  initial begin
    logic [127:0] got;
    logic [127:0] last_out;
    reset          = 1'b1;
    in_valid       = 1'b0;
    in_data        = '0;
    in_first       = 1'b0;
    iv             = '0;
    core_plaintext = '0;
    core_done      = 1'b0;
    out_ready      = 1'b0;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    check_reset_values("rst");

    // Known-answer message: first block with iv = 0, then the same block chained.
    do_block(KatCt, 1'b1, '0, 3, 0, 1'b0, got);
    check("kat1_out", got, KatPt);
    check("kat1_blk", 128'(blk_count), 128'(16'd1));
    do_block(KatCt, 1'b0, rand128(), 2, 10, 1'b1, got);
    check("kat2_out", got, 128'h69d5c2eb2e2e624750541d3bbc692ba5);
    check("kat2_blk", 128'(blk_count), 128'(16'd2));
    last_out = got;

    // Spurious core_done while idle is ignored.
    core_done      = 1'b1;
    core_plaintext = rand128();
    tick();
    core_done = 1'b0;
    tick();
    check("spur_idle_ready", 128'(in_ready), 128'(1'b1));
    check("spur_idle_no_out", 128'(out_valid), 128'(1'b0));
    check("spur_idle_no_start", 128'(core_start), 128'(1'b0));
    check("spur_idle_data", out_data, last_out);

    // core_done on the cycle the watchdog reaches its limit is a success.
    do_block(rand128(), 1'b0, '0, int'(Tmo), 1, 1'b0, got);
    check("edge_no_err", 128'(timeout_err), 128'(1'b0));

    // Core never answers: timeout, then next block still chains from the last good one.
    do_block(rand128(), 1'b0, '0, int'(Tmo) + 1, 0, 1'b0, got);
    do_block(rand128(), 1'b0, '0, 1, 0, 1'b0, got);

    // Reset while waiting, then a stale core_done.
    in_valid = 1'b1;
    in_data  = rand128();
    in_first = 1'b1;
    iv       = rand128();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    core_done      = 1'b1;
    core_plaintext = rand128();
    tick();
    core_done = 1'b0;
    check_reset_values("rst_wait");
    tick();
    check_reset_values("rst_wait2");

    // First block after reset without in_first chains with zero.
    do_block(rand128(), 1'b0, rand128(), 0, 0, 1'b0, got);

    // Randomised stream.
    for (int n = 0; n < 40; n++) begin
      int dly;
      dly = ($urandom_range(0, 15) == 0) ? int'(Tmo) + 1 : int'($urandom_range(0, 8));
      do_block(($urandom_range(0, 7) == 0) ? KatCt : rand128(),
               $urandom_range(0, 3) == 0, rand128(), dly, int'($urandom_range(0, 3)),
               $urandom_range(0, 1) != 0, got);
      if ($urandom_range(0, 3) == 0) begin
        core_done      = 1'b1;
        core_plaintext = rand128();
        tick();
        core_done = 1'b0;
        check("rnd_spur_no_out", 128'(out_valid), 128'(1'b0));
        check("rnd_spur_blk", 128'(blk_count), 128'(m_blk));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_cbc_dec_ctrl.md
AES_CBC_DEC_CTRL -- requirements
Module: aes_cbc_dec_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum number of cycles to wait for core_done before aborting.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 128), forming the ciphertext block handshake.
REQ-005 SHALL have port in_first, input, 1, qualified by in_valid, marking the first block of a message so that iv is used for chaining.
REQ-006 SHALL have port iv, input, 128, the initialisation vector, sampled only on an accepted in_first block.
REQ-007 SHALL have ports core_start (output, 1), core_ciphertext (output, 128), core_plaintext (input, 128) and core_done (input, 1), connecting to the decryption core.
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, 128), forming the plaintext block handshake.
REQ-009 SHALL have port blk_count, output, 16, counting plaintext blocks delivered in the current message.
REQ-010 SHALL have port timeout_err, output, 1, a sticky flag set on core timeout.

Function
REQ-011 SHALL implement FSM states IDLE, START, WAIT and OUT.
REQ-012 SHALL drive in_ready=1 only in IDLE; a transfer occurs when in_valid&&in_ready.
REQ-013 On a transfer, SHALL latch cur_ct<=in_data and chain<=(in_first ? iv : prev_ct); if in_first, SHALL clear blk_count; SHALL go to START.
REQ-014 In START, SHALL assert core_start for exactly 1 cycle and go to WAIT; core_ciphertext SHALL equal cur_ct from START until leaving WAIT.
REQ-015 In WAIT, on core_done=1, SHALL latch out_data<=core_plaintext XOR chain and prev_ct<=cur_ct, and go to OUT.
REQ-016 core_done outside WAIT SHALL be ignored.
REQ-017 In OUT, SHALL drive out_valid=1 with out_data stable; on out_ready=1, SHALL increment blk_count (wrapping 0xFFFF->0) and go to IDLE.
REQ-018 Latency: transfer at cycle T gives core_start at T+1; core_done at cycle D gives out_valid at D+1.
REQ-019 A WAIT counter SHALL start at 0 on entry and increment each WAIT cycle; when it reaches TIMEOUT_CYCLES without core_done, SHALL set timeout_err, leave prev_ct unchanged, produce no output, and go to IDLE.
REQ-020 core_done in the same cycle the counter reaches TIMEOUT_CYCLES SHALL count as success, with no error.
REQ-021 A block accepted without any prior in_first since reset SHALL chain with prev_ct=0.
REQ-022 timeout_err SHALL clear only on reset.
REQ-023 The block SHALL hold at most one block in flight; in_ready SHALL stay 0 until out_valid&&out_ready completes.

Reset
REQ-024 Reset SHALL force state=IDLE, with in_ready=1 in the following cycle.
REQ-025 Reset SHALL force core_start=0, out_valid=0, out_data=0, core_ciphertext=0, prev_ct=0, chain=0, blk_count=0, timeout_err=0 and the WAIT counter=0.
REQ-026 Reset mid-operation (START, WAIT or OUT) SHALL discard the block; the integrator SHALL reset the core concurrently, driving its reset_n from the inverse of reset.

Structure
REQ-027 Shared package aes_pkg SHALL hold the FSM state enum, BLOCK_W=128 and DEFAULT_TIMEOUT=64.
REQ-028 The WAIT counter SHALL be the single sub-module aes_wdog_cnt, with ports clear, enable, limit and expired.

Verification
REQ-029 Core model; key 000102030405060708090a0b0c0d0e0f, iv=0, in_first=1, in_data=69c4e0d86a7b0430d8cdb78070b4c55a -> out_data=00112233445566778899aabbccddeeff, blk_count=1.
REQ-030 Same stream, second block 69c4e0d86a7b0430d8cdb78070b4c55a with in_first=0 -> out_data=69d5c2eb2e2e624750541d3bbc692ba5, blk_count=2.
REQ-031 out_ready held 0 for 10 cycles in OUT -> out_data stable, in_ready=0 throughout, no second core_start.
REQ-032 Core model never asserts done -> timeout_err=1 exactly 64 WAIT cycles after entry, state IDLE, no out_valid.
REQ-033 Reset asserted in WAIT, then core_done pulse -> out_valid stays 0, in_ready=1, all outputs at reset values.
REQ-034 Spurious core_done while in IDLE -> no state change and no out_valid.
